// File: rtl/aes_pkg.sv
// Shared AES types, S-box/Rcon constants and key-schedule FSM states.
// Pure declarations: no latency, no flow control.
// KS_ZERO exists only when KEYSCHED_ZEROIZE_EN is defined.
package aes_pkg;

    typedef logic [3:0][7:0]  word_t;
    typedef logic [15:0][7:0] block_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

`ifdef KEYSCHED_ZEROIZE_EN
    typedef enum logic [1:0] {KS_IDLE, KS_EXPAND, KS_READY, KS_ZERO} ks_state_t;
`else
    typedef enum logic [1:0] {KS_IDLE, KS_EXPAND, KS_READY} ks_state_t;
`endif

endpackage

// File: rtl/sbox_word.sv
// Four parallel AES S-box lookups on one 32-bit word.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input word.
import aes_pkg::*;

module sbox_word (
    input  word_t din,
    output word_t dout
);

    always_comb begin
        dout = '0;
        for (int b = 0; b < 4; b++) begin
            dout[b] = SBOX[din[b]];
        end
    end

endmodule

// File: rtl/key_schedule_seq.sv
// Iterative AES key expansion, one word per cycle into a round-key buffer; KEYSCHED_ZEROIZE_EN adds buffer wipe.
// Latency: TOTAL-NK cycles from start to done; rd_key registered, one cycle after rd_round.
// Backpressure: start ignored while busy; no queuing, caller waits for done.
import aes_pkg::*;

module key_schedule_seq #(
    parameter int NK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic                  zeroize,
`endif
    input  logic [4*NK-1:0][7:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  key_valid,
    input  logic [3:0]            rd_round,
    output block_t                rd_key
);

    localparam int NR    = NK + 6;
    localparam int TOTAL = 4 * (NR + 1);

    generate
        if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
            $error("key_schedule_seq: NK must be 4, 6 or 8");
        end
    endgenerate

    ks_state_t  state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [2:0] phase_q, phase_d;   // i mod NK, kept as a counter to avoid a divider
    logic [3:0] rc_q, rc_d;
    logic       busy_d, done_d, kv_d;
    logic       load, wr_exp, wr_zero;

    word_t      w_q [TOTAL];
    word_t      prev, old, rot, sub_in, sub, t;
    block_t     rd_nxt;
    logic [5:0] rd_base;

    assign prev   = w_q[idx_q - 6'd1];
    assign old    = w_q[idx_q - 6'(NK)];
    assign rot    = {prev[0], prev[3], prev[2], prev[1]};
    assign sub_in = (phase_q == 3'd0) ? rot : prev;

    sbox_word u_sbox (
        .din  (sub_in),
        .dout (sub)
    );

    always_comb begin
        t = prev;
        if (phase_q == 3'd0) begin
            t = sub ^ word_t'({24'h0, RCON[rc_q]});
        end else if (NK == 8 && phase_q == 3'd4) begin
            t = sub;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        rc_d    = rc_q;
        busy_d  = busy;
        done_d  = 1'b0;
        kv_d    = key_valid;
        load    = 1'b0;
        wr_exp  = 1'b0;
        wr_zero = 1'b0;
`ifdef KEYSCHED_ZEROIZE_EN
        if (zeroize && state_q != KS_ZERO) begin
            state_d = KS_ZERO;
            idx_d   = '0;
            kv_d    = 1'b0;
            busy_d  = 1'b1;
        end else
`endif
        begin
            case (state_q)
                KS_IDLE, KS_READY: begin
                    if (start) begin
                        load    = 1'b1;
                        state_d = KS_EXPAND;
                        idx_d   = 6'(NK);
                        phase_d = '0;
                        rc_d    = '0;
                        kv_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                KS_EXPAND: begin
                    wr_exp  = 1'b1;
                    idx_d   = idx_q + 6'd1;
                    phase_d = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
                    if (phase_q == 3'd0) begin
                        rc_d = rc_q + 4'd1;
                    end
                    if (idx_q == 6'(TOTAL - 1)) begin
                        state_d = KS_READY;
                        done_d  = 1'b1;
                        kv_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
`ifdef KEYSCHED_ZEROIZE_EN
                KS_ZERO: begin
                    wr_zero = 1'b1;
                    idx_d   = idx_q + 6'd1;
                    if (idx_q == 6'(TOTAL - 1)) begin
                        state_d = KS_IDLE;
                        busy_d  = 1'b0;
                    end
                end
`endif
                default: state_d = KS_IDLE;
            endcase
        end
    end

    // Round r occupies words 4r..4r+3; out-of-range rounds read as zero.
    assign rd_base = {rd_round, 2'b00};

    always_comb begin
        rd_nxt = '0;
        if (rd_round <= 4'(NR)) begin
            for (int j = 0; j < 4; j++) begin
                rd_nxt[4*j +: 4] = w_q[rd_base + 6'(j)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KS_IDLE;
            idx_q     <= '0;
            phase_q   <= '0;
            rc_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            rd_key    <= '0;
            for (int k = 0; k < TOTAL; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            rc_q      <= rc_d;
            busy      <= busy_d;
            done      <= done_d;
            key_valid <= kv_d;
            rd_key    <= rd_nxt;
            if (load) begin
                for (int k = 0; k < NK; k++) begin
                    w_q[k] <= key_in[4*k +: 4];
                end
            end
            if (wr_exp) begin
                w_q[idx_q] <= old ^ t;
            end
            if (wr_zero) begin
                w_q[idx_q] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed FIPS-197 key-expansion vectors against NK=4/6/8 instances.
// Checks done latency, round-key reads, restart/reset behaviour and optional zeroize.
import aes_pkg::*;

module tb_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start4 = 1'b0, start6 = 1'b0, start8 = 1'b0;
    logic [3:0]   rd_round = '0;
    logic [15:0][7:0] key4;
    logic [23:0][7:0] key6;
    logic [31:0][7:0] key8;
    logic         busy4, done4, kv4, busy6, done6, kv6, busy8, done8, kv8;
    block_t       rk4, rk6, rk8;
`ifdef KEYSCHED_ZEROIZE_EN
    logic         zeroize4 = 1'b0;
    logic         zz_off = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_schedule_seq #(.NK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize4),
`endif
        .key_in(key4), .busy(busy4), .done(done4), .key_valid(kv4),
        .rd_round(rd_round), .rd_key(rk4)
    );

    key_schedule_seq #(.NK(6)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start6),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zz_off),
`endif
        .key_in(key6), .busy(busy6), .done(done6), .key_valid(kv6),
        .rd_round(rd_round), .rd_key(rk6)
    );

    key_schedule_seq #(.NK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zz_off),
`endif
        .key_in(key8), .busy(busy8), .done(done8), .key_valid(kv8),
        .rd_round(rd_round), .rd_key(rk8)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Hex literals are written in FIPS byte order (first byte leftmost); byte 0 lives at the LSB.
    function automatic block_t blk(input logic [127:0] x);
        block_t r;
        for (int b = 0; b < 16; b++) r[b] = x[127 - 8*b -: 8];
        return r;
    endfunction

    function automatic word_t wd(input logic [31:0] x);
        word_t r;
        for (int b = 0; b < 4; b++) r[b] = x[31 - 8*b -: 8];
        return r;
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            4: start4 = v;
            6: start6 = v;
            default: start8 = v;
        endcase
    endtask

    function automatic logic busy_of(input int which);
        return (which == 4) ? busy4 : (which == 6) ? busy6 : busy8;
    endfunction

    function automatic logic done_of(input int which);
        return (which == 4) ? done4 : (which == 6) ? done6 : done8;
    endfunction

    function automatic logic kv_of(input int which);
        return (which == 4) ? kv4 : (which == 6) ? kv6 : kv8;
    endfunction

    // Pulses start, counts edges from the load edge to the done pulse; optional second start mid-run.
    task automatic run(input int which, input int restart_at, output int cyc);
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
        check("busy_after_load", busy_of(which), 1);
        check("kv_low_expanding", kv_of(which), 0);
        cyc = 0;
        while (!done_of(which) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            set_start(which, cyc == restart_at);
        end
        set_start(which, 1'b0);
        check("kv_at_done", kv_of(which), 1);
        check("busy_at_done", busy_of(which), 0);
        @(posedge clk); #1;
        check("done_one_cycle", done_of(which), 0);
    endtask

    task automatic rd(input int which, input logic [3:0] r, output block_t v);
        rd_round = r;
        @(posedge clk); #1;
        v = (which == 4) ? rk4 : (which == 6) ? rk6 : rk8;
    endtask

    initial begin
        logic [191:0] k6lit;
        logic [255:0] k8lit;
        block_t       v;
        int           cyc;

        key4  = blk(128'h2b7e151628aed2a6abf7158809cf4f3c);
        k6lit = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        k8lit = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        for (int b = 0; b < 24; b++) key6[b] = k6lit[191 - 8*b -: 8];
        for (int b = 0; b < 32; b++) key8[b] = k8lit[255 - 8*b -: 8];

        #1;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_kv", kv4, 0);
        check("rst_rdkey", rk4, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run(4, -1, cyc);
        check("nk4_done_cycles", cyc, 40);
        rd(4, 4'd10, v);
        check("nk4_round10", v, blk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        check("nk4_w43", v[15:12], wd(32'hb6630ca6));
        rd(4, 4'd1, v);
        check("nk4_round1", v, blk(128'ha0fafe1788542cb123a339392a6c7605));
        rd(4, 4'd0, v);
        check("nk4_round0", v, key4);
        rd(4, 4'd11, v);
        check("nk4_round11_zero", v, 0);

        run(6, -1, cyc);
        check("nk6_done_cycles", cyc, 46);
        rd(6, 4'd12, v);
        check("nk6_w51", v[15:12], wd(32'h01002202));
        rd(6, 4'd13, v);
        check("nk6_round13_zero", v, 0);

        run(8, -1, cyc);
        check("nk8_done_cycles", cyc, 52);
        rd(8, 4'd14, v);
        check("nk8_w59", v[15:12], wd(32'h706c631e));
        rd(8, 4'd3, v);
        check("nk8_w12", v[3:0], wd(32'ha8b09c1a));

        // Re-expansion from READY with a stray start ten cycles in.
        run(4, 10, cyc);
        check("nk4_restart_ignored", cyc, 40);
        rd(4, 4'd10, v);
        check("nk4_reexpand_round10", v, blk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        // Asynchronous reset twenty cycles into an expansion.
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy4, 0);
        check("midrst_kv", kv4, 0);
        check("midrst_rdkey", rk4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(4, 4'd0, v);
        check("midrst_buf_clear", v, 0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_stays_idle", busy4, 0);

`ifdef KEYSCHED_ZEROIZE_EN
        run(4, -1, cyc);
        check("zz_pre_done_cycles", cyc, 40);
        @(negedge clk);
        zeroize4 = 1'b1;
        start4   = 1'b1;
        @(posedge clk); #1;
        zeroize4 = 1'b0;
        start4   = 1'b0;
        check("zz_busy_entry", busy4, 1);
        check("zz_kv_cleared", kv4, 0);
        cyc = 0;
        while (busy4 && cyc < 200) begin
            check("zz_no_done", done4, 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("zz_busy_cycles", cyc, 44);
        check("zz_kv_after", kv4, 0);
        for (int r = 0; r <= 10; r++) begin
            rd(4, 4'(r), v);
            check("zz_round_zero", v, 0);
        end
        check("zz_idle_not_busy", busy4, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
